// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Request/result bundle between the EX-stage control and the
//                multi-cycle multiply/divide unit.
//                master : control side (drives start/op/operands/MTHI/MTLO)
//                slave  : mult_div_unit (drives hi/lo/busy/done)
//  Signals     : start, op[1:0], in0, in1, hi_we, lo_we, wdata  (master out)
//                hi, lo, busy, done                             (slave out)
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, op, in0, in1, hi_we, lo_we, wdata,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, in0, in1, hi_we, lo_we, wdata,
      output hi, lo, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO
//                registers and MTHI/MTLO write path. One iteration per clock,
//                WIDTH iterations, then a sign-fix cycle that writes HI/LO.
//  Ports       : clk    - system clock
//                reset  - asynchronous, active-high
//                bus    - mult_div_unit_if.slave (start, op, in0, in1,
//                         hi_we, lo_we, wdata -> hi, lo, busy, done)
//  Revision    : 1.0  initial release
// ============================================================================
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            reset,
   mult_div_unit_if.slave bus
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   b_q, b_d;         // multiplicand or divisor (magnitude)
   logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial product | remainder, multiplier | quotient}
   logic               neg0_q, neg0_d;   // in0 was negative (signed ops only)
   logic               neg1_q, neg1_d;   // in1 was negative (signed ops only)
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // ---------------------------------------------------------------------
   // Iteration datapath
   // ---------------------------------------------------------------------
   logic [WIDTH:0]       w_mul_upper;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH:0]       w_div_shift;
   logic                 w_div_ge;
   logic [WIDTH-1:0]     w_div_rem;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [2*WIDTH-1:0]   w_prod_fix;
   logic [WIDTH-1:0]     w_quo_fix;
   logic [WIDTH-1:0]     w_rem_fix;
   logic                 w_signed_op;
   logic [WIDTH-1:0]     w_abs0;
   logic [WIDTH-1:0]     w_abs1;

   // Shift-add: add the multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right by one,
   // keeping the carry out of the add.
   assign w_mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign w_mul_next  = {w_mul_upper, acc_q[WIDTH-1:1]};

   // Restoring division: shift the next dividend bit into the remainder and
   // subtract the divisor when it fits. A successful subtract always leaves a
   // value below the divisor, so the low WIDTH bits of the difference are
   // the exact new remainder.
   assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, b_q});
   assign w_div_rem   = w_div_shift[WIDTH-1:0] - b_q;
   assign w_div_next  = w_div_ge ? {w_div_rem, acc_q[WIDTH-2:0], 1'b1}
                                 : {acc_q[2*WIDTH-2:0], 1'b0};

   // Sign correction applied in FIX. The neg flags are only ever set for the
   // signed ops, so the unsigned ops fall through untouched.
   assign w_prod_fix = (neg0_q ^ neg1_q) ? -acc_q : acc_q;
   assign w_quo_fix  = (neg0_q ^ neg1_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign w_rem_fix  = neg0_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   assign w_signed_op = ~bus.op[0];
   assign w_abs0      = (w_signed_op && bus.in0[WIDTH-1]) ? -bus.in0 : bus.in0;
   assign w_abs1      = (w_signed_op && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      b_d     = b_q;
      acc_d   = acc_q;
      neg0_d  = neg0_q;
      neg1_d  = neg1_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               // start wins over MTHI/MTLO in the same cycle
               state_d = S_RUN;
               op_d    = bus.op;
               neg0_d  = w_signed_op & bus.in0[WIDTH-1];
               neg1_d  = w_signed_op & bus.in1[WIDTH-1];
               cnt_d   = '0;
               busy_d  = 1'b1;
               if (bus.op[1]) begin
                  b_d   = w_abs1;
                  acc_d = {{WIDTH{1'b0}}, w_abs0};
               end else begin
                  b_d   = w_abs0;
                  acc_d = {{WIDTH{1'b0}}, w_abs1};
               end
            end else begin
               if (bus.hi_we) hi_d = bus.wdata;
               if (bus.lo_we) lo_d = bus.wdata;
            end
         end

         S_RUN: begin
            acc_d = op_q[1] ? w_div_next : w_mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end

         S_FIX: begin
            if (!op_q[1]) begin
               hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
               lo_d = w_prod_fix[WIDTH-1:0];
            end else if (b_q == '0) begin
               // With a zero divisor every trial subtract succeeds, so the
               // remainder half ends up holding |in0|; re-applying the
               // dividend sign returns in0 exactly.
               hi_d = w_rem_fix;
               lo_d = '1;
            end else begin
               hi_d = w_rem_fix;
               lo_d = w_quo_fix;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         neg0_q  <= 1'b0;
         neg1_q  <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         neg0_q  <= neg0_d;
         neg1_q  <= neg1_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
`default_nettype wire
